rca_word_sequencer: RTL and testbench

//  Upstream sequencer for the 8-bit ripple carry adder: adds two BYTES-wide operands
//  one byte per clock through an external RCA8bit instance, LS byte first.

---
 rtl/rca_word_sequencer_if.sv | 33 +++
 rtl/rca_word_sequencer.sv | 99 +++++++++
 tb/tb_rca_word_sequencer.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/rca_word_sequencer_if.sv
// Request/result and external-adder signals of the byte-serial word adder.
// slave = sequencer side, master = requester plus the RCA8bit it drives.
interface rca_word_sequencer_if #(
   parameter int BYTES = 4
);
   localparam int W = 8 * BYTES;

   logic          start;
   logic [W-1:0]  A_in;
   logic [W-1:0]  B_in;
   logic          Cin_in;
   logic          ready;
   logic          busy;
   logic          done;
   logic [W-1:0]  Sum_out;
   logic          Cout_out;
   logic          Ovf_out;
   logic [7:0]    Add_A;
   logic [7:0]    Add_B;
   logic          Add_Cin;
   logic [7:0]    Add_Sum;
   logic          Add_Cout;

   modport slave (
      input  start, A_in, B_in, Cin_in, Add_Sum, Add_Cout,
      output ready, busy, done, Sum_out, Cout_out, Ovf_out, Add_A, Add_B, Add_Cin
   );

   modport master (
      output start, A_in, B_in, Cin_in, Add_Sum, Add_Cout,
      input  ready, busy, done, Sum_out, Cout_out, Ovf_out, Add_A, Add_B, Add_Cin
   );
endinterface

// File: rtl/rca_word_sequencer.sv
// Adds two BYTES-wide operands one byte per clock through an external 8-bit RCA,
// LS byte first. Optional signed-overflow flag: define OVERFLOW_DETECT_EN.
module rca_word_sequencer #(
   parameter int BYTES = 4
) (
   input logic                 clk,
   input logic                 rst_n,
   rca_word_sequencer_if.slave bus
);
   localparam int IW = (BYTES > 1) ? $clog2(BYTES) : 1;

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

   state_t                    state;
   logic [IW-1:0]             idx;
   logic                      carry_r;
   logic [BYTES-1:0][7:0]     a_r;
   logic [BYTES-1:0][7:0]     b_r;
   logic [BYTES-1:0][7:0]     sum_r;
   logic                      cout_r;
   logic                      done_r;
   logic                      busy_r;
   logic                      ready_r;
   logic                      last;

   assign last = (idx == IW'(BYTES - 1));

   // The adder sees the current slice straight from the operand registers.
   assign bus.Add_A    = a_r[idx];
   assign bus.Add_B    = b_r[idx];
   assign bus.Add_Cin  = carry_r;
   assign bus.Sum_out  = sum_r;
   assign bus.Cout_out = cout_r;
   assign bus.done     = done_r;
   assign bus.busy     = busy_r;
   assign bus.ready    = ready_r;

`ifdef OVERFLOW_DETECT_EN
   logic ovf_r;
   assign bus.Ovf_out = ovf_r;
`else
   assign bus.Ovf_out = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         idx     <= '0;
         carry_r <= 1'b0;
         a_r     <= '0;
         b_r     <= '0;
         sum_r   <= '0;
         cout_r  <= 1'b0;
         done_r  <= 1'b0;
         busy_r  <= 1'b0;
         ready_r <= 1'b1;
`ifdef OVERFLOW_DETECT_EN
         ovf_r   <= 1'b0;
`endif
      end else begin
         done_r <= 1'b0;
         case (state)
            RUN: begin
               sum_r[idx] <= bus.Add_Sum;
               carry_r    <= bus.Add_Cout;
               idx        <= idx + 1'b1;
               if (last) begin
                  // Wrap idx so the adder never indexes past the top slice.
                  idx     <= '0;
                  cout_r  <= bus.Add_Cout;
`ifdef OVERFLOW_DETECT_EN
                  ovf_r   <= (a_r[BYTES-1][7] == b_r[BYTES-1][7]) &&
                             (bus.Add_Sum[7] != a_r[BYTES-1][7]);
`endif
                  state   <= DONE;
                  done_r  <= 1'b1;
                  busy_r  <= 1'b0;
                  ready_r <= 1'b1;
               end
            end
            default: begin
               if (bus.start) begin
                  a_r     <= bus.A_in;
                  b_r     <= bus.B_in;
                  carry_r <= bus.Cin_in;
                  idx     <= '0;
                  state   <= RUN;
                  busy_r  <= 1'b1;
                  ready_r <= 1'b0;
               end else begin
                  state   <= IDLE;
                  busy_r  <= 1'b0;
                  ready_r <= 1'b1;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_rca_word_sequencer.sv
// Self-checking bench: behavioural RCA8bit on Add_*, whole-word reference model.
module tb_rca_word_sequencer;
   localparam int BYTES = 4;
   localparam int W     = 8 * BYTES;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   rca_word_sequencer_if #(.BYTES(BYTES)) bus ();

   logic [8:0] add9;
   assign add9        = {1'b0, bus.Add_A} + {1'b0, bus.Add_B} + {8'd0, bus.Add_Cin};
   assign bus.Add_Sum  = add9[7:0];
   assign bus.Add_Cout = add9[8];

   rca_word_sequencer #(.BYTES(BYTES)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   int n_chk  = 0;
   int n_fail = 0;

   function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic cin);
      logic [W:0] s;
      logic       ovf;
      s   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
      ovf = 1'b0;
`ifdef OVERFLOW_DETECT_EN
      ovf = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
`endif
      return {ovf, s};
   endfunction

   // Called at a negedge; leaves at the negedge right after the accepting edge.
   task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
      bus.start  = 1'b1;
      bus.A_in   = a;
      bus.B_in   = b;
      bus.Cin_in = cin;
      @(negedge clk);
      bus.start  = 1'b0;
      bus.A_in   = $urandom;
      bus.B_in   = $urandom;
      bus.Cin_in = 1'($urandom);
   endtask

   task automatic wait_done(output int busy_cycles, output bit seen);
      busy_cycles = 0;
      seen        = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         if (bus.done) seen = 1'b1;
         else begin
            if (bus.busy) busy_cycles++;
            @(negedge clk);
         end
      end
   endtask

   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         output int busy_cycles, output bit seen);
      start_op(a, b, cin);
      wait_done(busy_cycles, seen);
   endtask

   task automatic test_reset();
      bus.start = 1'b0; bus.A_in = '0; bus.B_in = '0; bus.Cin_in = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_chk++; if (bus.ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", bus.ready); end
      n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
      n_chk++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", bus.done); end
      n_chk++; if (bus.Sum_out !== '0) begin n_fail++; $display("FAIL reset_sum got %h exp 0", bus.Sum_out); end
      n_chk++; if (bus.Cout_out !== 1'b0) begin n_fail++; $display("FAIL reset_cout got %b exp 0", bus.Cout_out); end
      n_chk++; if (bus.Ovf_out !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b exp 0", bus.Ovf_out); end
      n_chk++; if ({bus.Add_A, bus.Add_B, bus.Add_Cin} !== 17'd0) begin
         n_fail++; $display("FAIL reset_add got %h/%h/%b exp 0", bus.Add_A, bus.Add_B, bus.Add_Cin);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_directed();
      logic [W-1:0] ta [3] = '{32'h0000_00FF, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
      logic [W-1:0] tb [3] = '{32'h0000_0001, 32'h0000_0000, 32'h0000_0001};
      logic         tc [3] = '{1'b0, 1'b1, 1'b0};
      logic [W+1:0] e;
      int bc; bit seen;
      for (int i = 0; i < 3; i++) begin
         e = model(ta[i], tb[i], tc[i]);
         start_op(ta[i], tb[i], tc[i]);
         n_chk++; if (bus.ready !== 1'b0) begin n_fail++; $display("FAIL dir%0d_ready_run got %b exp 0", i, bus.ready); end
         wait_done(bc, seen);
         n_chk++; if (!seen) begin n_fail++; $display("FAIL dir%0d_timeout got no done exp done", i); end
         n_chk++; if (bc != BYTES) begin n_fail++; $display("FAIL dir%0d_busy got %0d exp %0d", i, bc, BYTES); end
         n_chk++; if (bus.Sum_out !== e[W-1:0]) begin n_fail++; $display("FAIL dir%0d_sum got %h exp %h", i, bus.Sum_out, e[W-1:0]); end
         n_chk++; if (bus.Cout_out !== e[W]) begin n_fail++; $display("FAIL dir%0d_cout got %b exp %b", i, bus.Cout_out, e[W]); end
         n_chk++; if (bus.Ovf_out !== e[W+1]) begin n_fail++; $display("FAIL dir%0d_ovf got %b exp %b", i, bus.Ovf_out, e[W+1]); end
         @(negedge clk);
         n_chk++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL dir%0d_done_pulse got %b exp 0", i, bus.done); end
         n_chk++; if (bus.Sum_out !== e[W-1:0]) begin n_fail++; $display("FAIL dir%0d_hold got %h exp %h", i, bus.Sum_out, e[W-1:0]); end
      end
   endtask

   task automatic test_ignore_start();
      logic [W+1:0] e;
      logic [W-1:0] a2, b2;
      logic         c2;
      int bc; bit seen;
      start_op(32'h2F, 32'h81, 1'b1);
      repeat (2) begin
         bus.start = 1'b1; bus.A_in = $urandom; bus.B_in = $urandom; bus.Cin_in = 1'($urandom);
         @(negedge clk);
      end
      bus.start = 1'b0;
      wait_done(bc, seen);
      n_chk++; if (!seen) begin n_fail++; $display("FAIL ign_timeout got no done exp done"); end
      n_chk++; if (bus.Sum_out !== 32'h0000_00B1) begin n_fail++; $display("FAIL ign_sum got %h exp 000000b1", bus.Sum_out); end
      n_chk++; if (bus.Cout_out !== 1'b0) begin n_fail++; $display("FAIL ign_cout got %b exp 0", bus.Cout_out); end
      a2 = $urandom; b2 = $urandom; c2 = 1'($urandom);
      e  = model(a2, b2, c2);
      start_op(a2, b2, c2);
      n_chk++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL done_start_busy got %b exp 1", bus.busy); end
      wait_done(bc, seen);
      n_chk++; if (!seen || bus.Sum_out !== e[W-1:0] || bus.Cout_out !== e[W]) begin
         n_fail++; $display("FAIL done_start_result got %b/%h exp %b/%h", bus.Cout_out, bus.Sum_out, e[W], e[W-1:0]);
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] qa [$], qb [$];
      logic         qc [$];
      logic [W+1:0] e;
      int bc, last_done; bit seen;
      for (int i = 0; i < 4; i++) begin
         qa.push_back($urandom); qb.push_back($urandom); qc.push_back(1'($urandom));
      end
      last_done = -1;
      start_op(qa[0], qb[0], qc[0]);
      for (int i = 0; i < 4; i++) begin
         wait_done(bc, seen);
         e = model(qa[i], qb[i], qc[i]);
         n_chk++; if (!seen || bus.Sum_out !== e[W-1:0] || bus.Cout_out !== e[W] || bus.Ovf_out !== e[W+1]) begin
            n_fail++; $display("FAIL b2b%0d got %b%b/%h exp %b%b/%h", i, bus.Ovf_out, bus.Cout_out, bus.Sum_out,
                               e[W+1], e[W], e[W-1:0]);
         end
         if (last_done >= 0) begin
            n_chk++; if (cyc - last_done != BYTES + 1) begin
               n_fail++; $display("FAIL b2b%0d_interval got %0d exp %0d", i, cyc - last_done, BYTES + 1);
            end
         end
         last_done = cyc;
         if (i < 3) start_op(qa[i+1], qb[i+1], qc[i+1]);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_run();
      logic [W-1:0] a2, b2;
      logic [W+1:0] e;
      int bc; bit seen, any_done;
      start_op(32'h1234_5678, 32'h1111_1111, 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_chk++; if ({bus.ready, bus.busy, bus.done} !== 3'b100) begin
         n_fail++; $display("FAIL midrst_flags got r%b b%b d%b exp r1 b0 d0", bus.ready, bus.busy, bus.done);
      end
      n_chk++; if (bus.Sum_out !== '0 || bus.Cout_out !== 1'b0 || bus.Ovf_out !== 1'b0) begin
         n_fail++; $display("FAIL midrst_outs got %b%b/%h exp 00/0", bus.Ovf_out, bus.Cout_out, bus.Sum_out);
      end
      n_chk++; if ({bus.Add_A, bus.Add_B, bus.Add_Cin} !== 17'd0) begin
         n_fail++; $display("FAIL midrst_add got %h/%h/%b exp 0", bus.Add_A, bus.Add_B, bus.Add_Cin);
      end
      any_done = 1'b0;
      repeat (3) begin @(negedge clk); if (bus.done) any_done = 1'b1; end
      rst_n = 1'b1;
      repeat (6) begin @(negedge clk); if (bus.done) any_done = 1'b1; end
      n_chk++; if (any_done) begin n_fail++; $display("FAIL midrst_no_done got done exp none"); end
      a2 = $urandom; b2 = $urandom;
      e  = model(a2, b2, 1'b1);
      run_op(a2, b2, 1'b1, bc, seen);
      n_chk++; if (!seen || bus.Sum_out !== e[W-1:0] || bus.Cout_out !== e[W] || bc != BYTES) begin
         n_fail++; $display("FAIL midrst_after got %b/%h busy%0d exp %b/%h busy%0d", bus.Cout_out, bus.Sum_out, bc,
                            e[W], e[W-1:0], BYTES);
      end
      @(negedge clk);
   endtask

   task automatic test_random();
      logic [W-1:0] corner [4] = '{32'h0, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000};
      logic [W-1:0] a, b;
      logic         c;
      logic [W+1:0] e;
      int bc; bit seen;
      for (int i = 0; i < 30; i++) begin
         a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom);
         b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom);
         c = 1'($urandom);
         e = model(a, b, c);
         run_op(a, b, c, bc, seen);
         n_chk++; if (!seen || bc != BYTES || bus.Sum_out !== e[W-1:0] || bus.Cout_out !== e[W] ||
                      bus.Ovf_out !== e[W+1]) begin
            n_fail++; $display("FAIL rnd%0d a=%h b=%h c=%b got %b%b/%h busy%0d exp %b%b/%h", i, a, b, c,
                               bus.Ovf_out, bus.Cout_out, bus.Sum_out, bc, e[W+1], e[W], e[W-1:0]);
         end
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_ignore_start();
      test_back_to_back();
      test_reset_mid_run();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
